one_io_bias: RTL and testbench



---
 rtl/one_io_bias_pkg.sv | 23 ++
 rtl/sat_add.sv | 31 +++
 rtl/one_io_bias.sv | 78 +++++++
 tb/tb_one_io_bias.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/one_io_bias_pkg.sv
// Shared types and helpers for the single-input neuron bias stage.
//   bias_state_t : control FSM encoding
//   DEF_WIDTH    : default activation/bias width
//   SAT_MAX/MIN  : signed range limits for a given width
package one_io_bias_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ADD          = 2'd1,
    WAIT_RELEASE = 2'd2
  } bias_state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int SAT_MAX(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int SAT_MIN(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder with optional clamp to the signed range.
//   a, b     : two's-complement operands
//   sum      : clamped (SATURATE=1) or wrapped (SATURATE=0) result
//   overflow : sum did not fit in WIDTH bits (debug observation only)
module sat_add
  import one_io_bias_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter bit SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(SAT_MAX(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(SAT_MIN(WIDTH));

  logic [WIDTH:0] sum_ext;

  always_comb begin
    sum_ext  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // Extended sign and top result bit disagree only when the true sum
    // left the WIDTH-bit signed range; the extended sign tells which side.
    overflow = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
    sum      = sum_ext[WIDTH-1:0];
    if (SATURATE && overflow) sum = sum_ext[WIDTH] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/one_io_bias.sv
// Single-input neuron bias stage: captures an activation and a bias on an
// enable assertion, adds them (saturating or wrapping) and presents the
// result with a one-cycle ready pulse. A held enable never retriggers.
//   clk, rst_n  : clock, async active-low reset
//   in          : activation operand, captured at the start edge
//   biased_val  : bias operand, captured with in
//   enable      : level start request, one operation per assertion
//   ready       : one-cycle pulse when biased_out carries a new result
//   biased_out  : registered result, held until the next one
module one_io_bias
  import one_io_bias_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] biased_val,
  input  logic             enable,
  output logic             ready,
  output logic [WIDTH-1:0] biased_out
);

  bias_state_t      state, state_nxt;
  logic             cap_en, out_en;
  logic [WIDTH-1:0] op_a, op_b, sum;
  logic             add_ovf_unused; // debug tap, no consumer

  sat_add #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_sat_add (
    .a        (op_a),
    .b        (op_b),
    .sum      (sum),
    .overflow (add_ovf_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    out_en    = 1'b0;
    case (state)
      IDLE: if (enable) begin
        cap_en    = 1'b1;
        state_nxt = ADD;
      end
      ADD: begin
        out_en    = 1'b1;
        // Enable already low: skip the release wait so the next start
        // can land two edges after this one.
        state_nxt = enable ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      biased_out <= '0;
      ready      <= 1'b0;
    end else begin
      ready <= out_en;
      if (cap_en) begin
        op_a <= in;
        op_b <= biased_val;
      end
      if (out_en) biased_out <= sum;
    end
  end

endmodule

// File: tb/tb_one_io_bias.sv
module tb_one_io_bias;

  logic       clk, rst_n, en;
  logic [7:0] in_d, bv_d;
  logic       ready_s, ready_w;
  logic [7:0] out_s, out_w;

  int checks = 0;
  int errors = 0;

  // Reference model state: operations described by start edge and captured
  // operands; a new start needs enable seen low at some edge after the last.
  int         edge_n = 0, start_edge = -10;
  bit         pend = 0, can_start = 1;
  int         m_a = 0, m_b = 0;
  logic       exp_ready = 0;
  logic [7:0] exp_s = 0, exp_w = 0;

  one_io_bias #(.WIDTH(8), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in(in_d), .biased_val(bv_d),
    .enable(en), .ready(ready_s), .biased_out(out_s)
  );

  one_io_bias #(.WIDTH(8), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in(in_d), .biased_val(bv_d),
    .enable(en), .ready(ready_w), .biased_out(out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    pend = 0; can_start = 1; exp_ready = 0; exp_s = 0; exp_w = 0;
  endtask

  // Drive one cycle, advance the model across the edge, settle #1 after it.
  task automatic tick(input logic e, input logic [7:0] a, input logic [7:0] b);
    int s;
    en = e; in_d = a; bv_d = b;
    @(posedge clk);
    edge_n++;
    exp_ready = pend && (edge_n == start_edge + 1);
    if (exp_ready) begin
      s = m_a + m_b;
      exp_s = (s > 127) ? 8'h7F : (s < -128) ? 8'h80 : 8'(s);
      exp_w = 8'(s);
      pend = 0;
    end
    if (e && can_start) begin
      m_a = int'($signed(a)); m_b = int'($signed(b));
      start_edge = edge_n; pend = 1; can_start = 0;
    end else if (!e) can_start = 1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; in_d = '0; bv_d = '0;
    #2;
    checks++; if (ready_s !== 1'b0 || ready_w !== 1'b0) begin errors++; $display("FAIL reset_ready got %b/%b want 0", ready_s, ready_w); end
    checks++; if (out_s !== 8'h00 || out_w !== 8'h00) begin errors++; $display("FAIL reset_out got %h/%h want 00", out_s, out_w); end
    en = 1'b1; in_d = 8'd9; bv_d = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready_s !== 1'b0 || out_s !== 8'h00) begin errors++; $display("FAIL reset_hold got r=%b o=%h want 0/00", ready_s, out_s); end
    en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      tick(i < 2, 8'd5, 8'd5);
      checks++; if (ready_s !== exp_ready) begin errors++; $display("FAIL basic_ready[%0d] got %b want %b", i, ready_s, exp_ready); end
      checks++; if (out_s !== exp_s) begin errors++; $display("FAIL basic_out[%0d] got %h want %h", i, out_s, exp_s); end
      if (i == 1) begin
        checks++; if (ready_s !== 1'b1 || out_s !== 8'd10) begin errors++; $display("FAIL basic_const got r=%b o=%0d want 1/10", ready_s, out_s); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] ta [5] = '{8'd100, 8'h9C, 8'd127, 8'h80, 8'hFF};
    logic [7:0] tb_ [5] = '{8'd100, 8'h9C, 8'd1,   8'hFF, 8'h01};
    logic [7:0] cs [5] = '{8'h7F, 8'h80, 8'h7F, 8'h80, 8'h00};
    logic [7:0] cw [5] = '{8'hC8, 8'h38, 8'h80, 8'h7F, 8'h00};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, ta[i], tb_[i]);
      tick(1'b0, 'x, 'x);
      checks++; if (ready_s !== 1'b1 || ready_w !== 1'b1) begin errors++; $display("FAIL sat_ready[%0d] got %b/%b want 1", i, ready_s, ready_w); end
      checks++; if (out_s !== cs[i]) begin errors++; $display("FAIL sat_clamp[%0d] got %h want %h", i, out_s, cs[i]); end
      checks++; if (out_w !== cw[i]) begin errors++; $display("FAIL sat_wrap[%0d] got %h want %h", i, out_w, cw[i]); end
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8'd9, 8'd9);
      if (ready_s === 1'b1) pulses++;
      checks++; if (ready_s !== exp_ready) begin errors++; $display("FAIL hold_ready[%0d] got %b want %b", i, ready_s, exp_ready); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", pulses); end
    tick(1'b0, 'x, 'x);
    tick(1'b1, 8'hFD, 8'd7);
    tick(1'b0, 'x, 'x);
    checks++; if (ready_s !== 1'b1 || out_s !== 8'd4 || out_w !== 8'd4) begin errors++; $display("FAIL hold_second got r=%b o=%h/%h want 1/04", ready_s, out_s, out_w); end
  endtask

  task automatic test_operand_change();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 8'($urandom), 8'($urandom));
      tick(1'b1, 8'($urandom), 8'($urandom));
      checks++; if (ready_s !== 1'b1 || out_s !== exp_s || out_w !== exp_w) begin errors++; $display("FAIL opchg[%0d] got r=%b o=%h/%h want 1 %h/%h", i, ready_s, out_s, out_w, exp_s, exp_w); end
      tick(1'b0, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 8'd3, 8'd4);
    tick(1'b0, 'x, 'x);
    checks++; if (out_s !== 8'd7) begin errors++; $display("FAIL rstmid_pre got %h want 07", out_s); end
    tick(1'b1, 8'd50, 8'd20);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (ready_s !== 1'b0 || out_s !== 8'h00 || out_w !== 8'h00) begin errors++; $display("FAIL rstmid_now got r=%b o=%h/%h want 0/00", ready_s, out_s, out_w); end
    repeat (2) @(posedge clk);
    en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 'x, 'x);
      checks++; if (ready_s !== 1'b0 || out_s !== 8'h00) begin errors++; $display("FAIL rstmid_after[%0d] got r=%b o=%h want 0/00", i, ready_s, out_s); end
    end
  endtask

  task automatic test_idle_x();
    tick(1'b1, 8'hF0, 8'h05);
    tick(1'b0, 'x, 'x);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 'x, 'x);
      checks++; if (ready_s !== 1'b0 || out_s !== 8'hF5 || out_w !== 8'hF5) begin errors++; $display("FAIL idle_x[%0d] got r=%b o=%h/%h want 0/f5", i, ready_s, out_s, out_w); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom));
      checks++; if (ready_s !== exp_ready || ready_w !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b/%b want %b", i, ready_s, ready_w, exp_ready); end
      checks++; if (out_s !== exp_s) begin errors++; $display("FAIL rand_sat[%0d] got %h want %h", i, out_s, exp_s); end
      checks++; if (out_w !== exp_w) begin errors++; $display("FAIL rand_wrap[%0d] got %h want %h", i, out_w, exp_w); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_hold();
    test_operand_change();
    test_reset_mid();
    test_idle_x();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
